// File: rtl/pe_csa_mac.sv
`default_nettype none
// ============================================================================
// Module      : pe_csa_mac (with helper pe_csa_cpa)
// Description : Weight-stationary systolic PE. Signed 8x8 MAC that keeps the
//               running partial sum in carry-save form, plus a resolving CPA.
// Revision    : 1.0 - initial release
// ============================================================================

// Carry-propagate adder that resolves one carry-save pair into a binary sum.
module pe_csa_cpa #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

module pe_csa_mac #(
    parameter  int SIZE = 4,
    localparam int PW   = $clog2(SIZE) + 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wload,
    input  logic [7:0]    weight,
    input  logic [7:0]    in,
    input  logic [PW-1:0] psum0,
    input  logic [PW-1:0] psum1,
    output logic [7:0]    weight_o,
    output logic [7:0]    in_o,
    output logic [PW-1:0] psum_o0,
    output logic [PW-1:0] psum_o1,
    output logic [PW:0]   psum_res
);

    // Baugh-Wooley correction: +2^8 and -2^15, the latter expressed mod 2^PW
    // so the product rows can live directly at the partial-sum width.
    localparam logic [PW-1:0] C_BW_CORR = ({PW{1'b1}} << 15) | (PW'(1) << 8);

    function automatic logic [PW-1:0] f_csa_sum(
        input logic [PW-1:0] x,
        input logic [PW-1:0] y,
        input logic [PW-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    function automatic logic [PW-1:0] f_csa_cy(
        input logic [PW-1:0] x,
        input logic [PW-1:0] y,
        input logic [PW-1:0] z
    );
        logic [PW-1:0] m;
        m = (x & y) | (x & z) | (y & z);
        return {m[PW-2:0], 1'b0};
    endfunction

    logic [7:0]    r_wreg;
    logic [7:0]    r_in;
    logic [PW-1:0] r_row0;
    logic [PW-1:0] r_row1;

    logic [PW-1:0] w_pp [8];

    // Row j holds a_i*b_j at weight i+j; terms that mix exactly one sign bit
    // are complemented.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_pp[j] = '0;
            for (int i = 0; i < 8; i++) begin
                w_pp[j][i+j] = (r_wreg[i] & in[j]) ^ ((i == 7) != (j == 7));
            end
        end
    end

    // 3:2 tree reducing nine rows (eight partial products + correction) to two
    logic [PW-1:0] w_s1a, w_c1a, w_s1b, w_c1b, w_s1c, w_c1c;
    logic [PW-1:0] w_s2a, w_c2a, w_s2b, w_c2b;
    logic [PW-1:0] w_s3, w_c3;
    logic [PW-1:0] w_m0, w_m1;
    logic [PW-1:0] w_s5, w_c5;
    logic [PW-1:0] w_n0, w_n1;

    assign w_s1a = f_csa_sum(w_pp[0], w_pp[1], w_pp[2]);
    assign w_c1a = f_csa_cy (w_pp[0], w_pp[1], w_pp[2]);
    assign w_s1b = f_csa_sum(w_pp[3], w_pp[4], w_pp[5]);
    assign w_c1b = f_csa_cy (w_pp[3], w_pp[4], w_pp[5]);
    assign w_s1c = f_csa_sum(w_pp[6], w_pp[7], C_BW_CORR);
    assign w_c1c = f_csa_cy (w_pp[6], w_pp[7], C_BW_CORR);

    assign w_s2a = f_csa_sum(w_s1a, w_c1a, w_s1b);
    assign w_c2a = f_csa_cy (w_s1a, w_c1a, w_s1b);
    assign w_s2b = f_csa_sum(w_c1b, w_s1c, w_c1c);
    assign w_c2b = f_csa_cy (w_c1b, w_s1c, w_c1c);

    assign w_s3  = f_csa_sum(w_s2a, w_c2a, w_s2b);
    assign w_c3  = f_csa_cy (w_s2a, w_c2a, w_s2b);

    assign w_m0  = f_csa_sum(w_s3, w_c3, w_c2b);
    assign w_m1  = f_csa_cy (w_s3, w_c3, w_c2b);

    // 4:2 stage merging the product pair with the incoming partial sum pair
    assign w_s5  = f_csa_sum(w_m0, w_m1, psum0);
    assign w_c5  = f_csa_cy (w_m0, w_m1, psum0);
    assign w_n0  = f_csa_sum(w_s5, w_c5, psum1);
    assign w_n1  = f_csa_cy (w_s5, w_c5, psum1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wreg <= '0;
            r_in   <= '0;
            r_row0 <= '0;
            r_row1 <= '0;
        end else begin
            if (wload) begin
                r_wreg <= weight;
            end
            r_in   <= in;
            r_row0 <= w_n0;
            r_row1 <= w_n1;
        end
    end

    assign weight_o = r_wreg;
    assign in_o     = r_in;
    assign psum_o0  = r_row0;
    assign psum_o1  = r_row1;

    pe_csa_cpa #(
        .W (PW)
    ) u_cpa (
        .a   (r_row0),
        .b   (r_row1),
        .sum (psum_res)
    );

endmodule
`default_nettype wire

// File: tb/tb_pe_csa_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_csa_mac
// Description : Self-checking bench for pe_csa_mac against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_csa_mac;

    localparam int SIZE = 4;
    localparam int PW   = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          wload;
    logic [7:0]    weight;
    logic [7:0]    in;
    logic [PW-1:0] psum0;
    logic [PW-1:0] psum1;
    logic [7:0]    weight_o;
    logic [7:0]    in_o;
    logic [PW-1:0] psum_o0;
    logic [PW-1:0] psum_o1;
    logic [PW:0]   psum_res;

    pe_csa_mac #(
        .SIZE (SIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wload    (wload),
        .weight   (weight),
        .in       (in),
        .psum0    (psum0),
        .psum1    (psum1),
        .weight_o (weight_o),
        .in_o     (in_o),
        .psum_o0  (psum_o0),
        .psum_o1  (psum_o1),
        .psum_res (psum_res)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            m_w    = 0;
    logic [PW-1:0] exp_sum;
    logic [7:0]    exp_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: weight register as a signed int, MAC as plain integer arithmetic mod 2^PW.
    task automatic step(input logic r, input logic wl, input logic [7:0] wt,
                        input logic [7:0] a, input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        int full;
        rst = r; wload = wl; weight = wt; in = a; psum0 = p0; psum1 = p1;
        if (r) begin
            exp_sum = '0;
            exp_in  = '0;
            m_w     = 0;
        end else begin
            full    = int'(p0) + int'(p1) + m_w * int'($signed(a));
            exp_sum = full[PW-1:0];
            exp_in  = a;
            if (wl) m_w = int'($signed(wt));
        end
        @(posedge clk);
        #1;
        chk("weight_o", 32'(weight_o), 32'(m_w & 255));
        chk("in_o", 32'(in_o), 32'(exp_in));
        chk("res", 32'(psum_res[PW-1:0]), 32'(exp_sum));
        chk("rowsum", 32'(PW'(psum_o0 + psum_o1)), 32'(exp_sum));
    endtask

    function automatic logic [PW-1:0] sext16(input logic [15:0] v);
        return {{(PW-16){v[15]}}, v};
    endfunction

    logic [18:0] rows_u;

    initial begin
        rst = 1'b1; wload = 1'b0; weight = '0; in = '0; psum0 = '0; psum1 = '0;

        // Reset with arbitrary inputs, wload asserted to confirm rst priority
        step(1'b1, 1'b1, 8'h55, 8'h33, 18'h2ABCD, 18'h11111);
        chk("rst_psum_o0", 32'(psum_o0), 32'd0);
        chk("rst_psum_o1", 32'(psum_o1), 32'd0);
        chk("rst_psum_res", 32'(psum_res), 32'd0);

        // Basic MAC
        step(1'b0, 1'b1, 8'd3, 8'd0, '0, '0);
        step(1'b0, 1'b0, 8'd0, 8'd5, 18'd10, '0);
        chk("basic_res", 32'(psum_res[PW-1:0]), 32'd25);

        // Signed extremes
        step(1'b0, 1'b1, 8'h80, 8'd0, '0, '0);
        step(1'b0, 1'b1, 8'hFF, 8'h80, '0, '0);
        chk("neg128sq", 32'(psum_res[PW-1:0]), 32'd16384);
        step(1'b0, 1'b0, 8'd0, 8'd127, 18'h3FFFB, 18'd2);
        chk("neg130", 32'(psum_res[PW-1:0]), 32'h3FF7E);

        // Wrap-around
        step(1'b0, 1'b1, 8'd1, 8'd0, '0, '0);
        step(1'b0, 1'b0, 8'd0, 8'd1, 18'h1FFFF, 18'h20000);
        chk("wrap_res", 32'(psum_res[PW-1:0]), 32'd0);
        rows_u = {1'b0, psum_o0} + {1'b0, psum_o1};
        chk("wrap_carry", 32'(psum_res[PW]), 32'(rows_u[18]));
        step(1'b0, 1'b0, 8'd0, 8'd0, 18'h3FFFF, 18'd1);
        chk("wrap_res2", 32'(psum_res[PW-1:0]), 32'd0);

        // Weight hold and load ordering
        step(1'b0, 1'b1, 8'd3, 8'd0, '0, '0);
        step(1'b0, 1'b0, 8'd7, 8'd2, '0, '0);
        chk("hold_uses3", 32'(psum_res[PW-1:0]), 32'd6);
        step(1'b0, 1'b1, 8'd7, 8'd2, '0, '0);
        chk("load_uses_old", 32'(psum_res[PW-1:0]), 32'd6);
        step(1'b0, 1'b0, 8'd0, 8'd2, '0, '0);
        chk("next_uses7", 32'(psum_res[PW-1:0]), 32'd14);

        // Randomized vectors with a mid-stream reset
        for (int i = 0; i < 120; i++) begin
            logic [PW-1:0] p0;
            logic [PW-1:0] p1;
            p0 = sext16(16'($urandom));
            p1 = ($urandom_range(0, 3) == 0) ? PW'($urandom) : sext16(16'($urandom));
            if (i == 60) begin
                step(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), p0, p1);
                chk("mid_rst_res", 32'(psum_res), 32'd0);
            end else begin
                step(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), p0, p1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
